// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single 64-bit memory port: instruction fetch (read-only)
// and data access (load/store), round-robin on conflict, fixed-latency read capture.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_ack,
  output logic [63:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              owner_dm_reg, owner_dm_next;
  logic              last_dm_reg, last_dm_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [63:0]       wdata_reg, wdata_next;
  logic [31:0]       if_rdata_reg, if_rdata_next;
  logic [63:0]       dm_rdata_reg, dm_rdata_next;
  logic              mem_en_reg, mem_we_reg;
  logic              if_ack_reg, dm_ack_reg;
  logic              grant_dm;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    owner_dm_next = owner_dm_reg;
    last_dm_next  = last_dm_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    grant_dm      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (if_req || dm_req) begin
          // DM wins only when alone or when fetch was served last.
          grant_dm      = dm_req && (!if_req || !last_dm_reg);
          owner_dm_next = grant_dm;
          last_dm_next  = grant_dm;
          addr_next     = grant_dm ? dm_addr : if_addr;
          we_next       = grant_dm && dm_we;
          wdata_next    = grant_dm ? dm_wdata : 64'd0;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = RESP;
        end else begin
          cnt_next   = LAT_INIT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          if (owner_dm_reg) begin
            dm_rdata_next = mem_rdata;
          end else begin
            if_rdata_next = addr_reg[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      owner_dm_reg <= 1'b0;
      last_dm_reg  <= 1'b1;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 64'd0;
      if_rdata_reg <= 32'd0;
      dm_rdata_reg <= 64'd0;
      mem_en_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      if_ack_reg   <= 1'b0;
      dm_ack_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      owner_dm_reg <= owner_dm_next;
      last_dm_reg  <= last_dm_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
      // Strobes are decoded from the next state so they are plain flop outputs.
      mem_en_reg   <= (state_next == ISSUE);
      mem_we_reg   <= (state_next == ISSUE) && we_next;
      if_ack_reg   <= (state_next == RESP) && !owner_dm_next;
      dm_ack_reg   <= (state_next == RESP) && owner_dm_next;
    end
  end

  assign if_ack    = if_ack_reg;
  assign dm_ack    = dm_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, checked
// against a transaction-level model (grant order, issue/ack cycles, read data).
module tb_mem_port_arbiter;
  parameter int RD_LAT = 2;
  localparam int ADDR_W = 32;

  logic              clock;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [63:0]       dm_wdata;
  logic              dm_ack;
  logic [63:0]       dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] init_word(input int idx);
    if (idx == 0) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {32'(idx) * 32'h9E37_79B9, 32'(idx) ^ 32'h5A5A_0F0F};
  endfunction

  // Memory responder: fixed read latency, poison on non-read cycles.
  logic [63:0] mem [int];
  logic [63:0] pipe [RD_LAT];
  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge clock) begin
    int idx;
    idx = int'(mem_addr[ADDR_W-1:3]);
    if (mem_en && mem_we) mem[idx] = mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? (mem.exists(idx) ? mem[idx] : init_word(idx))
                                   : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model state
  logic [63:0] ref_mem [int];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          free_cyc, en_cyc, ack_cyc, grant_cyc;
  bit          m_active, m_owner_dm, m_we, m_last_dm;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [31:0] exp_if_rd, pend_if_rd;
  logic [63:0] exp_dm_rd, pend_dm_rd;
  logic [31:0] exp_mem_addr;
  int          n_if_done, n_dm_done;
  int          last_if_ack_cyc, last_dm_ack_cyc;
  bit          got_if_ack, got_dm_ack;
  int          ack_hist [$];

  function automatic logic [63:0] ref_word(input logic [31:0] a);
    int idx;
    idx = int'(a[31:3]);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input int p_if, input int p_dm, input bit scramble);
    bit e_en, e_we, e_ifa, e_dma, acked_if, acked_dm, pick_dm;
    logic [63:0] word;
    if (m_active && cyc == ack_cyc) begin
      if (m_owner_dm && !m_we) exp_dm_rd = pend_dm_rd;
      if (!m_owner_dm) exp_if_rd = pend_if_rd;
    end
    e_en  = m_active && (cyc == en_cyc);
    e_we  = e_en && m_we;
    e_ifa = m_active && (cyc == ack_cyc) && !m_owner_dm;
    e_dma = m_active && (cyc == ack_cyc) && m_owner_dm;
    if (e_en) exp_mem_addr = m_addr;
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("if_ack", 64'(if_ack), 64'(e_ifa));
    chk("dm_ack", 64'(dm_ack), 64'(e_dma));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
    chk("dm_rdata", dm_rdata, exp_dm_rd);
    chk("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
    if (e_we) chk("mem_wdata", mem_wdata, m_wdata);

    if (m_active && cyc == ack_cyc) begin
      m_active = 1'b0;
      if (m_owner_dm) n_dm_done++;
      else n_if_done++;
    end

    acked_if = (if_ack === 1'b1);
    acked_dm = (dm_ack === 1'b1);
    if (acked_if) begin
      if_req = 1'b0; last_if_ack_cyc = cyc; got_if_ack = 1'b1; ack_hist.push_back(0);
    end
    if (acked_dm) begin
      dm_req = 1'b0; last_dm_ack_cyc = cyc; got_dm_ack = 1'b1; ack_hist.push_back(1);
    end

    if (scramble && m_active && cyc > grant_cyc) begin
      if (!m_owner_dm && if_req) if_addr = $urandom;
      if (m_owner_dm && dm_req) begin
        dm_addr  = $urandom;
        dm_wdata = {$urandom, $urandom};
      end
    end

    if (!if_req && !acked_if && int'($urandom_range(99)) < p_if) begin
      if_addr = (32'($urandom_range(15)) << 3) | (32'($urandom_range(1)) << 2);
      if_req  = 1'b1;
    end
    if (!dm_req && !acked_dm && int'($urandom_range(99)) < p_dm) begin
      dm_we    = 1'($urandom_range(1));
      dm_addr  = 32'($urandom_range(15)) << 3;
      dm_wdata = {$urandom, $urandom};
      dm_req   = 1'b1;
    end

    if (!m_active && cyc >= free_cyc && (if_req || dm_req)) begin
      pick_dm    = dm_req && (!if_req || !m_last_dm);
      m_last_dm  = pick_dm;
      m_owner_dm = pick_dm;
      m_we       = pick_dm && dm_we;
      m_addr     = pick_dm ? dm_addr : if_addr;
      m_wdata    = dm_wdata;
      grant_cyc  = cyc;
      en_cyc     = cyc + 1;
      ack_cyc    = cyc + 2 + (m_we ? 0 : RD_LAT);
      free_cyc   = ack_cyc + 1;
      m_active   = 1'b1;
      if (m_we) begin
        ref_mem[int'(m_addr[31:3])] = m_wdata;
      end else begin
        word       = ref_word(m_addr);
        pend_dm_rd = word;
        pend_if_rd = m_addr[2] ? word[63:32] : word[31:0];
      end
    end

    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic run_until(input bit want_dm, input int p_dm, input string tag);
    int n;
    n = 0;
    got_if_ack = 1'b0;
    got_dm_ack = 1'b0;
    while (!(want_dm ? got_dm_ack : got_if_ack) && n < 200) begin
      step(0, p_dm, 1'b0);
      n++;
    end
    chk({tag, "_ack_seen"}, 64'(n < 200), 64'd1);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_if_ack", 64'(if_ack), 64'd0);
    chk("rst_dm_ack", 64'(dm_ack), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_dm_rdata", dm_rdata, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    m_active     = 1'b0;
    m_last_dm    = 1'b1;
    exp_if_rd    = 32'd0;
    exp_dm_rd    = 64'd0;
    exp_mem_addr = 32'd0;
    repeat (hold) begin
      @(posedge clock);
      cyc++;
    end
    @(negedge clock);
    chk("rst_hold_mem_en", 64'(mem_en), 64'd0);
    chk("rst_hold_dm_ack", 64'(dm_ack), 64'd0);
    reset    = 1'b1;
    free_cyc = cyc;
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = 64'd0;
    n_if_done = 0; n_dm_done = 0;
    @(negedge clock);
    do_reset(3);

    // Single fetch from the upper half of doubleword 0
    if_addr = 32'h4; if_req = 1'b1; t0 = cyc;
    run_until(1'b0, 0, "t1");
    chk("t1_latency", 64'(last_if_ack_cyc - t0), 64'(2 + RD_LAT));
    chk("t1_if_rdata", 64'(if_rdata), 64'hAAAA_BBBB);

    // Store then load the same doubleword
    dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 64'h1122_3344_5566_7788; dm_req = 1'b1; t0 = cyc;
    run_until(1'b1, 0, "t2_sd");
    chk("t2_sd_latency", 64'(last_dm_ack_cyc - t0), 64'd2);
    dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 64'd0; dm_req = 1'b1; t0 = cyc;
    run_until(1'b1, 0, "t2_ld");
    chk("t2_ld_latency", 64'(last_dm_ack_cyc - t0), 64'(2 + RD_LAT));
    chk("t2_ld_data", dm_rdata, 64'h1122_3344_5566_7788);

    // Conflicts from reset alternate IF, DM, IF, DM
    do_reset(2);
    ack_hist.delete();
    for (int r = 0; r < 2; r++) begin
      if_addr = 32'h10; if_req = 1'b1;
      dm_we = 1'b0; dm_addr = 32'h48; dm_req = 1'b1;
      run_until(1'b1, 0, "t3");
    end
    chk("t3_ack_count", 64'(ack_hist.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_order", 64'(ack_hist.size() > i ? ack_hist[i] : 2), 64'(i % 2));

    // Sustained DM traffic must not starve a held fetch
    repeat (3) step(0, 100, 1'b0);
    if_addr = 32'h20; if_req = 1'b1; t0 = cyc;
    run_until(1'b0, 100, "t4");
    chk("t4_no_starvation", 64'((last_if_ack_cyc - t0) <= 2 * (2 + RD_LAT) + 2), 64'd1);
    repeat (2 * (RD_LAT + 4)) step(0, 0, 1'b0);

    // Reset during the wait phase of a load, then re-serve the held request
    dm_we = 1'b0; dm_addr = 32'h40; dm_req = 1'b1;
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    do_reset(2);
    t0 = cyc;
    run_until(1'b1, 0, "t5");
    chk("t5_latency", 64'(last_dm_ack_cyc - t0), 64'(2 + RD_LAT));
    chk("t5_dm_rdata", dm_rdata, ref_word(32'h40));

    // Random mixed traffic with operands scrambled after grant
    repeat (2000) step(30, 30, 1'b1);
    repeat (2 * (RD_LAT + 4)) step(0, 0, 1'b0);
    chk("rand_if_served", 64'(n_if_done > 20), 64'd1);
    chk("rand_dm_served", 64'(n_dm_done > 20), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
